reimu_shot_pool: RTL
====================

Name: reimu_shot_pool

Overview:
- Player-bullet manager that sits directly upstream of the RGB mixer.
- Consumes the decoded shoot request and reimu's sprite position, and keeps a fixed pool of upward-moving shots.
- Advances the pool once per frame during vertical blanking.
- For the current raster pixel (h_cnt/v_cnt), produces a registered "shot pixel" flag that the RGB stage uses to paint bullets.

Parameters:
- NUM_SHOTS, 8: number of bullet slots in the pool.
- SHOT_W, 4: bullet width in pixels.
- SHOT_H, 12: bullet height in pixels.
- SHOT_SPEED, 8: upward movement per frame, in pixels.
- COOLDOWN, 6: minimum spacing between spawns, in frames (must be ≥ 1).
- SPRITE_W, 32: reimu sprite width, used to centre the spawn point.

Ports:
- clk  in  1  pixel clock; top level connects clk_25MHz.
- rst  in  1  asynchronous, active-low reset.
- fire  in  1  level; high while the shoot key is held (decoder_sig shoot).
- reimux  in  10  reimu sprite top-left x.
- reimuy  in  10  reimu sprite top-left y.
- h_cnt  in  10  current pixel column from vga_controller.
- v_cnt  in  10  current pixel row from vga_controller.
- valid  in  1  active-video flag from vga_controller.
- shot_px  out  1  registered flag: current pixel lies inside an active bullet.
- shot_count  out  4  number of active slots (width is $clog2(NUM_SHOTS+1)).
- spawn_pulse  out  1  one-clk pulse when a bullet is spawned (for an SFX hook).

Behaviour:
- Reset (rst=0, async): all slots inactive with x=y=0; cooldown=0; shot_px=0; shot_count=0; spawn_pulse=0; frame-edge flag=0.
- Frame tick: cond = (v_cnt==480 && h_cnt==0). Internal tick is high for exactly one clk on the first cycle cond is true while the previous-cycle cond register is false. One tick per frame, always inside blanking, so positions never change mid-visible-frame (no tearing).
- On a tick, movement for each active slot:
  - if y < SHOT_SPEED, the slot goes inactive;
  - otherwise y <= y - SHOT_SPEED.
  - x never changes.
  - Unsigned 10-bit arithmetic; no wrap is possible because of the guard above.
- On a tick, spawn:
  - Allowed when fire==1, cooldown==0, and at least one slot was inactive at tick start. Slots freed by this tick's movement are not reusable until the next tick.
  - Allocate the lowest-index free slot.
  - x = reimux + SPRITE_W/2 - SHOT_W/2, 10-bit truncated.
  - y = reimuy - SHOT_H, clamped to 0 when reimuy < SHOT_H.
  - cooldown <= COOLDOWN-1.
  - spawn_pulse = 1 for that clk.
- Cooldown on a tick with no spawn: if cooldown != 0, decrement; otherwise hold at 0.
- Pool full with fire held: no spawn, cooldown stays 0, and the spawn is retried on every later tick.
- fire is sampled only on the tick; presses that fall between ticks are ignored.
- shot_count: registered popcount of the active bits, updated the clk after the tick.
- shot_px:
  - Registered, 1-clk latency relative to h_cnt/v_cnt.
  - Value = valid AND OR over active slots of (x ≤ h_cnt < x+SHOT_W AND y ≤ v_cnt < y+SHOT_H).
  - Compare in 11 bits so x+SHOT_W does not overflow.
  - valid=0 forces 0.
- Reset mid-frame: clears everything immediately; the first tick after release behaves like a fresh start.
- Port/frame edge: a bullet at y=0 is still drawn that frame and deactivated on the next tick.

Decomposition:
- Package shot_pkg holds:
  - constants SCREEN_H_ACTIVE=480 and TICK_LINE=480;
  - the default SHOT_W/SHOT_H/SHOT_SPEED/SPRITE_W values;
  - a function for the shot_count width.
- One sub-module, shot_slot, instantiated NUM_SHOTS times. It holds active/x/y, takes move/load strobes plus spawn x/y, and outputs a combinational hit for (h_cnt, v_cnt).
- The parent module owns tick detection, the cooldown counter, the priority allocator, the popcount, and the shot_px register.

Test Plan:
- Spawn/position:
  - Stimulus: rst pulse, then fire=1 with reimux=300, reimuy=400, held over one tick, then fire=0.
  - Response: slot0 x=314, y=388; shot_count=1 one clk after the tick; spawn_pulse high for 1 clk.
  - After the next tick, y=380.
- Pixel hit/latency:
  - Stimulus: with the bullet at (314,380), drive valid=1 and visit (h,v) = (314,380), (317,391), (318,380), (314,392), (313,380).
  - Response: shot_px = 1, 1, 0, 0, 0, each one clk later.
  - With valid=0 at (314,380): shot_px=0.
- Cooldown:
  - Stimulus: fire held for 20 ticks, pool never full.
  - Response: spawns exactly on ticks 0, 6, 12 and 18; shot_count=4 after tick 18.
- Pool full:
  - Stimulus: COOLDOWN=1, reimuy=400, fire held for 10 ticks.
  - Response: spawns on ticks 0–7, none on ticks 8–9; shot_count saturates at 8; slots 0–7 are filled in index order.
- Top exit:
  - Stimulus: a bullet spawned with reimuy=20 (y=8).
  - Response: tick 1 gives y=0 with the bullet still active; tick 2 deactivates it and shot_count returns to 0.
  - With reimuy=5, spawn y is clamped to 0.
- Async reset mid-frame:
  - Stimulus: 3 active bullets, shot_px=1; pull rst low between clk edges.
  - Response: shot_px=0 and shot_count=0 immediately.
  - After release, with fire=1, the next tick spawns into slot0.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared constants and helpers for the player-shot pool.
package shot_pkg;

  localparam int SCREEN_H_ACTIVE = 480;
  localparam int TICK_LINE       = 480;

  localparam int DEF_SHOT_W     = 4;
  localparam int DEF_SHOT_H     = 12;
  localparam int DEF_SHOT_SPEED = 8;
  localparam int DEF_SPRITE_W   = 32;

  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shot_slot.sv
// One bullet slot: holds position and activity, reports a raster hit.
module shot_slot
  import shot_pkg::*;
#(
  parameter int SHOT_W     = DEF_SHOT_W,
  parameter int SHOT_H     = DEF_SHOT_H,
  parameter int SHOT_SPEED = DEF_SHOT_SPEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move,
  input  logic       load,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  output logic       active,
  output logic       hit
);

  logic [9:0]  x;
  logic [9:0]  y;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (load) begin
      active <= 1'b1;
      x      <= spawn_x;
      y      <= spawn_y;
    end else if (move && active) begin
      // Retire before subtracting so y can never wrap past the top.
      if (y < 10'(SHOT_SPEED)) active <= 1'b0;
      else                     y      <= y - 10'(SHOT_SPEED);
    end
  end

  // 11-bit compare keeps x+SHOT_W / y+SHOT_H from overflowing.
  always_comb begin
    x_ext = {1'b0, x};
    y_ext = {1'b0, y};
    h_ext = {1'b0, h_cnt};
    v_ext = {1'b0, v_cnt};
    hit   = active
         && (h_ext >= x_ext) && (h_ext < x_ext + 11'(SHOT_W))
         && (v_ext >= y_ext) && (v_ext < y_ext + 11'(SHOT_H));
  end

endmodule

// File: rtl/reimu_shot_pool.sv
// Player-shot pool: per-frame movement and spawn, raster hit flag for the RGB mixer.
module reimu_shot_pool
  import shot_pkg::*;
#(
  parameter int NUM_SHOTS  = 8,
  parameter int SHOT_W     = DEF_SHOT_W,
  parameter int SHOT_H     = DEF_SHOT_H,
  parameter int SHOT_SPEED = DEF_SHOT_SPEED,
  parameter int COOLDOWN   = 6,
  parameter int SPRITE_W   = DEF_SPRITE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fire,
  input  logic [9:0]                    reimux,
  input  logic [9:0]                    reimuy,
  input  logic [9:0]                    h_cnt,
  input  logic [9:0]                    v_cnt,
  input  logic                          valid,
  output logic                          shot_px,
  output logic [count_w(NUM_SHOTS)-1:0] shot_count,
  output logic                          spawn_pulse
);

  localparam int CNT_W = count_w(NUM_SHOTS);
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  function automatic logic [9:0] sub_clamp(input logic [9:0] a, input int b);
    return (a < 10'(b)) ? 10'd0 : a - 10'(b);
  endfunction

  logic                 cond;
  logic                 cond_q;
  logic                 tick;
  logic [CD_W-1:0]      cooldown;
  logic [NUM_SHOTS-1:0] active;
  logic [NUM_SHOTS-1:0] hit;
  logic [NUM_SHOTS-1:0] sel;
  logic [NUM_SHOTS-1:0] load;
  logic                 found;
  logic                 spawn;
  logic [9:0]           spawn_x;
  logic [9:0]           spawn_y;
  logic [CNT_W-1:0]     pop;
  logic                 px_p0;

  assign cond    = (v_cnt == 10'(TICK_LINE)) && (h_cnt == 10'd0);
  assign tick    = cond && !cond_q;
  assign spawn_x = reimux + 10'(SPRITE_W / 2 - SHOT_W / 2);
  assign spawn_y = sub_clamp(reimuy, SHOT_H);

  // Allocation uses activity at tick start, so slots retiring on this tick stay unavailable.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (!active[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    spawn = tick && fire && (cooldown == '0) && found;
    load  = spawn ? sel : '0;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SHOTS; i++) pop = pop + CNT_W'(active[i]);
    px_p0 = valid && (|hit);
  end

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    shot_slot #(
      .SHOT_W    (SHOT_W),
      .SHOT_H    (SHOT_H),
      .SHOT_SPEED(SHOT_SPEED)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .move   (tick),
      .load   (load[g]),
      .spawn_x(spawn_x),
      .spawn_y(spawn_y),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .active (active[g]),
      .hit    (hit[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cond_q      <= 1'b0;
      cooldown    <= '0;
      spawn_pulse <= 1'b0;
      shot_count  <= '0;
      shot_px     <= 1'b0;
    end else begin
      cond_q      <= cond;
      spawn_pulse <= spawn;
      shot_count  <= pop;
      shot_px     <= px_p0;
      if (tick) begin
        if (spawn)                cooldown <= CD_W'(COOLDOWN - 1);
        else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
      end
    end
  end

endmodule
